// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared tick prescaler drives per-channel
// OFF/ON/BLINK/ONESHOT sequencers, reprogrammable at any time over a valid/ready port.
module led_pattern_gen #(
  parameter int CLK_HZ     = 12000000,
  parameter int TICK_HZ    = 1000,
  parameter int CHANNELS   = 3,
  parameter int CNT_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_on,
  input  logic [CNT_W-1:0]    cfg_off,
  output logic [CHANNELS-1:0] led_out,
  output logic                tick_out
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_tick;
  logic                r_ready;
  logic [CHANNELS-1:0] r_led;
  logic                w_div_wrap;
  logic                w_wr;

  logic [1:0]          r_mode     [CHANNELS];
  logic [CNT_W-1:0]    r_on       [CHANNELS];
  logic [CNT_W-1:0]    r_off      [CHANNELS];
  logic [CNT_W-1:0]    r_cnt      [CHANNELS];
  logic [CHANNELS-1:0] r_lit;

  logic [1:0]          w_mode_nxt [CHANNELS];
  logic [CNT_W-1:0]    w_on_nxt   [CHANNELS];
  logic [CNT_W-1:0]    w_off_nxt  [CHANNELS];
  logic [CNT_W-1:0]    w_cnt_nxt  [CHANNELS];
  logic [CNT_W-1:0]    w_dur      [CHANNELS];
  logic [CHANNELS-1:0] w_lit_nxt;

  assign w_div_wrap = (r_div_cnt == DIV_W'(DIV - 1));
  // Out-of-range channel numbers complete the handshake but touch nothing.
  assign w_wr       = cfg_valid && r_ready && (int'(cfg_chan) < CHANNELS);

  // Next-state per channel; a write to a channel overrides that channel's tick.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_mode_nxt[i] = r_mode[i];
      w_on_nxt[i]   = r_on[i];
      w_off_nxt[i]  = r_off[i];
      w_cnt_nxt[i]  = r_cnt[i];
      w_lit_nxt[i]  = r_lit[i];
      w_dur[i]      = r_lit[i] ? r_on[i] : r_off[i];
      if (w_wr && (cfg_chan == CH_W'(i))) begin
        w_mode_nxt[i] = cfg_mode;
        w_on_nxt[i]   = (cfg_on == '0)  ? CNT_W'(1) : cfg_on;
        w_off_nxt[i]  = (cfg_off == '0) ? CNT_W'(1) : cfg_off;
        w_cnt_nxt[i]  = '0;
        w_lit_nxt[i]  = (cfg_mode == MODE_ON) || (cfg_mode == MODE_BLINK) ||
                        (cfg_mode == MODE_ONESHOT);
      end else if (r_tick && (r_mode[i] == MODE_BLINK || r_mode[i] == MODE_ONESHOT)) begin
        if (r_cnt[i] == w_dur[i] - CNT_W'(1)) begin
          w_cnt_nxt[i] = '0;
          if (r_mode[i] == MODE_ONESHOT) begin
            w_mode_nxt[i] = MODE_OFF;
            w_lit_nxt[i]  = 1'b0;
          end else begin
            w_lit_nxt[i]  = ~r_lit[i];
          end
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
      r_ready   <= 1'b0;
      r_led     <= {CHANNELS{ACTIVE_LOW}};
      r_lit     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i] <= MODE_OFF;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      r_tick    <= w_div_wrap;
      r_ready   <= 1'b1;
      // Registered from next-state so the pin follows a write one cycle later.
      r_led     <= w_lit_nxt ^ {CHANNELS{ACTIVE_LOW}};
      r_lit     <= w_lit_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i] <= w_mode_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
      end
    end
  end

  // Durations are only read in BLINK/ONESHOT, which always load them first.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      r_on[i]  <= w_on_nxt[i];
      r_off[i] <= w_off_nxt[i];
    end
  end

  assign led_out   = r_led;
  assign tick_out  = r_tick;
  assign cfg_ready = r_ready;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random config traffic, all
// compared each cycle against a phase-remaining-ticks model of the channels.
module tb_led_pattern_gen;
  localparam int DIV = 5;
  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_chan = '0;
  logic [1:0]     cfg_mode = '0;
  logic [CW-1:0]  cfg_on = '0;
  logic [CW-1:0]  cfg_off = '0;
  logic [NCH-1:0] led_out;
  logic           tick_out;

  led_pattern_gen #(
    .CLK_HZ(10), .TICK_HZ(2), .CHANNELS(NCH), .CNT_W(CW), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
    .led_out(led_out), .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int tq[$];

  // Model: mode, ticks left in current phase, durations, lit flag.
  int m_mode[NCH];
  int m_rem[NCH];
  int m_on[NCH];
  int m_off[NCH];
  bit m_lit[NCH];
  int m_n = 0;
  bit m_tick = 1'b0;
  bit m_ready = 1'b0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic int clamp(int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic step();
    bit tk, xf;
    int ch, md, on, off;
    logic [NCH-1:0] exp_led;
    tk  = m_tick;
    xf  = cfg_valid && m_ready;
    ch  = int'(cfg_chan);
    md  = int'(cfg_mode);
    on  = clamp(int'(cfg_on));
    off = clamp(int'(cfg_off));
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_tick = 1'b0; m_ready = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_lit[c] = 1'b0; m_rem[c] = 0;
      end
    end else begin
      m_n++;
      for (int c = 0; c < NCH; c++) begin
        if (xf && ch == c) begin
          m_mode[c] = md; m_on[c] = on; m_off[c] = off;
          m_lit[c] = (md != 0); m_rem[c] = on;
        end else if (tk && m_mode[c] >= 2) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            if (m_mode[c] == 3) begin
              m_mode[c] = 0; m_lit[c] = 1'b0;
            end else begin
              m_lit[c] = !m_lit[c];
              m_rem[c] = m_lit[c] ? m_on[c] : m_off[c];
            end
          end
        end
      end
      m_ready = 1'b1;
      m_tick  = (m_n % DIV == 0);
    end
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) exp_led[c] = ~m_lit[c];
    check("led_out", 32'(led_out), 32'(exp_led));
    check("tick_out", 32'(tick_out), 32'(m_tick));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic write(int ch, int md, int on, int off);
    cfg_chan = 2'(ch); cfg_mode = 2'(md); cfg_on = CW'(on); cfg_off = CW'(off);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic steps_to_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_out && n < 50);
  endtask

  task automatic measure(int ch, int ncyc);
    logic prev;
    tq.delete();
    prev = led_out[ch];
    repeat (ncyc) begin
      step();
      if (led_out[ch] != prev) begin
        tq.push_back(cyc);
        prev = led_out[ch];
      end
    end
  endtask

  initial begin
    int n, lit;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_rem[c] = 0; m_on[c] = 1; m_off[c] = 1; m_lit[c] = 1'b0;
    end

    // Reset state and prescaler cadence
    rst = 1'b1;
    run(3);
    check("rst_led", 32'(led_out), 32'h7);
    check("rst_tick", 32'(tick_out), 0);
    check("rst_ready", 32'(cfg_ready), 0);
    rst = 1'b0;
    step();
    check("ready_post_rst", 32'(cfg_ready), 1);
    steps_to_tick(n);
    check("first_tick", n + 1, 5);
    steps_to_tick(n);
    check("tick_period", n, 5);

    // BLINK on=2 off=3 on ch1
    write(1, 2, 2, 3);
    check("blink_start", 32'(led_out[1]), 0);
    measure(1, 90);
    check("blink_edges", 32'(tq.size() >= 4), 1);
    if (tq.size() >= 4) begin
      check("blink_off_len", tq[1] - tq[0], 15);
      check("blink_on_len", tq[2] - tq[1], 10);
      check("blink_off_len2", tq[3] - tq[2], 15);
    end
    check("ch0_idle", 32'(led_out[0]), 1);
    check("ch2_idle", 32'(led_out[2]), 1);

    // ONESHOT on=4 on ch0, then ON
    write(0, 3, 4, 0);
    lit = (led_out[0] == 1'b0) ? 1 : 0;
    repeat (40) begin
      step();
      if (led_out[0] == 1'b0) lit++;
    end
    check("oneshot_len_ok", 32'(lit >= 16 && lit <= 20), 1);
    run(200);
    check("oneshot_done", 32'(led_out[0]), 1);
    write(0, 1, 0, 0);
    run(30);
    check("ch0_on", 32'(led_out[0]), 0);

    // Invalid channel, then collisions of writes with a tick
    write(3, 1, 5, 5);
    check("invalid_ready", 32'(cfg_ready), 1);
    n = 0;
    while (!tick_out && n < 20) begin step(); n++; end
    check("tick_seen", 32'(tick_out), 1);
    write(1, 0, 0, 0);
    check("coll_off", 32'(led_out[1]), 1);
    n = 0;
    while (!tick_out && n < 20) begin step(); n++; end
    check("tick_seen2", 32'(tick_out), 1);
    write(2, 2, 1, 1);
    check("coll_blink_lit", 32'(led_out[2]), 0);
    run(50);
    check("ch1_stays_off", 32'(led_out[1]), 1);

    // Zero-duration clamp
    write(2, 2, 0, 0);
    measure(2, 40);
    check("clamp_edges", 32'(tq.size() >= 3), 1);
    if (tq.size() >= 3) begin
      check("clamp_off_len", tq[1] - tq[0], 5);
      check("clamp_on_len", tq[2] - tq[1], 5);
    end

    // Reset mid-pattern
    write(0, 2, 2, 2);
    write(1, 2, 3, 1);
    write(2, 3, 9, 0);
    run(7);
    rst = 1'b1;
    step();
    check("midrst_led", 32'(led_out), 32'h7);
    check("midrst_tick", 32'(tick_out), 0);
    check("midrst_ready", 32'(cfg_ready), 0);
    rst = 1'b0;
    steps_to_tick(n);
    check("tick_after_rst", n, 5);
    run(30);
    check("no_resume", 32'(led_out), 32'h7);

    // Random traffic against the model
    repeat (2500) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!rst && $urandom_range(0, 19) == 0) begin
        cfg_chan  = 2'($urandom_range(0, 3));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_on    = CW'($urandom_range(0, 6));
        cfg_off   = CW'($urandom_range(0, 6));
        cfg_valid = 1'b1;
      end
      step();
      cfg_valid = 1'b0;
    end
    rst = 1'b0;
    run(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
